// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage: IDLE/REQ/WAIT/FULL with redirect kill.
// Optional retired-fetch counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
`endif
  output logic [1:0]  fsm_state
);

  // Handshakes: a request is issued on any cycle with imem_req=1 and imem_gnt=1;
  // a response is taken only in WAIT on imem_rvalid=1; decode consumes the held
  // instruction on any cycle with instr_valid=1 and instr_ready=1 unless a
  // redirect arrives in the same cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } state_e;

  state_e      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        kill, kill_nxt;
  logic        capture;
  logic        handshake;
  logic [31:0] redirect_aligned;
  logic        unused_low_bits;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign unused_low_bits  = ^redirect_pc[1:0];

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (redirect_valid) pc_nxt = redirect_aligned;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_nxt = redirect_aligned;
          // A grant in the redirect cycle still leaves a response in flight.
          if (imem_gnt) begin
            state_nxt = S_WAIT;
            kill_nxt  = 1'b1;
          end
        end else if (imem_gnt) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redirect_aligned;
          if (imem_rvalid) begin
            state_nxt = S_REQ;
            kill_nxt  = 1'b0;
          end else begin
            kill_nxt  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            state_nxt = S_REQ;
            kill_nxt  = 1'b0;
          end else begin
            capture   = 1'b1;
            pc_nxt    = pc + 32'd4;
            state_nxt = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_aligned;
          state_nxt = S_REQ;
        end else if (instr_ready) begin
          handshake = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      instr    <= 32'd0;
      instr_pc <= 32'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      kill  <= kill_nxt;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_FULL);
  assign fsm_state   = state;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) perf_fetch_cnt <= 32'd0;
    else if (handshake) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, then randomized memory/decode traffic
// checked against a stream-level model of expected fetch addresses.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
`endif
    .fsm_state      (dbg_state)
  );

  typedef struct {
    logic        rst_n;
    logic        rd_v;
    logic [31:0] rd_pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        chk_data;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    logic [31:0] e_perf;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic row(input logic rs, input logic rdv, input logic [31:0] rdpc, input logic g,
                     input logic rv, input logic [31:0] rdat, input logic rdy,
                     input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                     input logic cd, input logic [31:0] e_ipc, input logic [31:0] e_instr,
                     input logic [31:0] e_perf);
    vec_t v;
    v.rst_n = rs; v.rd_v = rdv; v.rd_pc = rdpc; v.gnt = g; v.rv = rv; v.rdata = rdat;
    v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.chk_data = cd;
    v.e_ipc = e_ipc; v.e_instr = e_instr; v.e_perf = e_perf;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rs, input logic rdv, input logic [31:0] rdpc, input logic g,
                       input logic rv, input logic [31:0] rdat, input logic rdy);
    rst_n = rs; redirect_valid = rdv; redirect_pc = rdpc; imem_gnt = g;
    imem_rvalid = rv; imem_rdata = rdat; instr_ready = rdy;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Random-phase model state
  logic [31:0] exp_q[$];        // addresses of granted requests still awaiting a response
  int          delay;
  logic [31:0] exp_pc, held_pc, held_instr, perf_exp, prev_addr, rdpc, rdat;
  logic        holding, prev_req, prev_gnt, prev_rd, rd, rdy, gnt, rv;
  int          deliveries;

  initial begin
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);

    // rst rdv rd_pc g rv rdata rdy | req addr iv chk ipc instr perf
    row(0,0,32'h0,0,0,32'h0,0,            0,32'h0,0,1,32'h0,32'h0,0);
    row(0,0,32'h0,0,1,32'hDEAD_BEEF,0,    0,32'h0,0,1,32'h0,32'h0,0);
    row(1,0,32'h0,0,0,32'h0,0,            1,32'h0,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,1,0,32'h0,0,            0,32'h0,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,1,32'h1111_0000,1,    0,32'h4,1,1,32'h0,32'h1111_0000,0);
    row(1,0,32'h0,0,0,32'h0,1,            1,32'h4,0,0,32'h0,32'h0,1);
    row(1,0,32'h0,1,0,32'h0,0,            0,32'h4,0,0,32'h0,32'h0,1);
    row(1,0,32'h0,0,0,32'h0,0,            0,32'h4,0,0,32'h0,32'h0,1);
    row(1,0,32'h0,0,1,32'h2222_0004,0,    0,32'h8,1,1,32'h4,32'h2222_0004,1);
    row(1,0,32'h0,0,0,32'h0,0,            0,32'h8,1,1,32'h4,32'h2222_0004,1);
    row(1,0,32'h0,0,1,32'hDEAD_0001,0,    0,32'h8,1,1,32'h4,32'h2222_0004,1);
    row(1,0,32'h0,0,0,32'h0,0,            0,32'h8,1,1,32'h4,32'h2222_0004,1);
    row(1,0,32'h0,0,0,32'h0,0,            0,32'h8,1,1,32'h4,32'h2222_0004,1);
    row(1,0,32'h0,0,0,32'h0,1,            1,32'h8,0,0,32'h0,32'h0,2);
    row(1,0,32'h0,1,0,32'h0,0,            0,32'h8,0,0,32'h0,32'h0,2);
    row(1,1,32'h103,0,0,32'h0,0,          0,32'h100,0,0,32'h0,32'h0,2);
    row(1,0,32'h0,0,1,32'h3333_0008,0,    1,32'h100,0,0,32'h0,32'h0,2);
    row(1,0,32'h0,1,0,32'h0,0,            0,32'h100,0,0,32'h0,32'h0,2);
    row(1,0,32'h0,0,1,32'h4444_0100,0,    0,32'h104,1,1,32'h100,32'h4444_0100,2);
    row(1,1,32'hFFFF_FFFE,0,0,32'h0,1,    1,32'hFFFF_FFFC,0,0,32'h0,32'h0,2);
    row(1,1,32'h200,1,0,32'h0,0,          0,32'h200,0,0,32'h0,32'h0,2);
    row(1,0,32'h0,0,1,32'h5555_0000,0,    1,32'h200,0,0,32'h0,32'h0,2);
    row(1,1,32'hFFFF_FFFC,0,0,32'h0,0,    1,32'hFFFF_FFFC,0,0,32'h0,32'h0,2);
    row(1,0,32'h0,1,0,32'h0,0,            0,32'hFFFF_FFFC,0,0,32'h0,32'h0,2);
    row(1,1,32'h300,0,1,32'h6666_0000,0,  1,32'h300,0,0,32'h0,32'h0,2);
    row(1,1,32'hFFFF_FFFD,0,0,32'h0,0,    1,32'hFFFF_FFFC,0,0,32'h0,32'h0,2);
    row(1,0,32'h0,1,0,32'h0,0,            0,32'hFFFF_FFFC,0,0,32'h0,32'h0,2);
    row(1,0,32'h0,0,1,32'h7777_FFFC,0,    0,32'h0,1,1,32'hFFFF_FFFC,32'h7777_FFFC,2);
    row(1,0,32'h0,0,0,32'h0,1,            1,32'h0,0,0,32'h0,32'h0,3);
    row(1,0,32'h0,1,0,32'h0,0,            0,32'h0,0,0,32'h0,32'h0,3);
    row(0,0,32'h0,0,0,32'h0,0,            0,32'h0,0,1,32'h0,32'h0,0);
    row(1,0,32'h0,0,1,32'h8888_0000,0,    1,32'h0,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,1,32'h9999_0000,0,    1,32'h0,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,1,0,32'h0,0,            0,32'h0,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,1,32'hAAAA_0000,0,    0,32'h4,1,1,32'h0,32'hAAAA_0000,0);
    row(1,0,32'h0,0,0,32'h0,1,            1,32'h4,0,0,32'h0,32'h0,1);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].rd_v, tbl[i].rd_pc, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d_imem_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("row%0d_imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_instr_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_iv});
      if (tbl[i].chk_data) begin
        chk($sformatf("row%0d_instr_pc", i), instr_pc, tbl[i].e_ipc);
        chk($sformatf("row%0d_instr", i), instr, tbl[i].e_instr);
      end
`ifdef FETCH_PERF_CNT_EN
      chk($sformatf("row%0d_perf", i), perf_fetch_cnt, tbl[i].e_perf);
`endif
    end

    // Randomized phase: reset, then random grants, latencies, stalls, redirects, stray responses.
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    delay = 0; exp_pc = 32'h0; holding = 1'b0; perf_exp = 32'd0; deliveries = 0;
    held_pc = 32'd0; held_instr = 32'd0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_rd = 1'b0; prev_addr = 32'd0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (imem_req) begin
        chk("one_outstanding", exp_q.size(), 32'd0);
        chk("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
      end
      if (prev_req && !prev_gnt && !prev_rd && imem_req) chk("addr_stable", imem_addr, prev_addr);
      if (instr_valid) begin
        if (!holding) begin
          chk("rnd_instr_pc", instr_pc, exp_pc);
          chk("rnd_instr", instr, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          holding = 1'b1; held_pc = instr_pc; held_instr = instr;
          deliveries++;
        end else begin
          chk("hold_instr_pc", instr_pc, held_pc);
          chk("hold_instr", instr, held_instr);
        end
      end else if (holding) begin
        chk("valid_held", {31'd0, instr_valid}, 32'd1);
        holding = 1'b0;
      end

      rd = ($urandom_range(0, 15) == 0);
      rdpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      gnt = imem_req && ($urandom_range(0, 2) != 0);
      rdat = $urandom;
      rv = 1'b0;
      if (exp_q.size() != 0 && delay == 0) begin
        rv = 1'b1;
        rdat = mem_word(exp_q[0]);
      end else if (exp_q.size() == 0 && $urandom_range(0, 7) == 0) begin
        rv = 1'b1;
      end
      drive(1'b1, rd, rdpc, gnt, rv, rdat, rdy);

      if (exp_q.size() != 0) begin
        if (rv) void'(exp_q.pop_front());
        else delay--;
      end
      if (imem_req && gnt) begin
        exp_q.push_back(imem_addr);
        delay = $urandom_range(0, 3);
      end
      if (instr_valid && (rdy || rd)) holding = 1'b0;
      if (instr_valid && rdy && !rd) perf_exp = perf_exp + 32'd1;
      if (rd) exp_pc = rdpc & ~32'h3;
      prev_req = imem_req; prev_gnt = gnt; prev_rd = rd; prev_addr = imem_addr;

      @(posedge clk);
      @(negedge clk);
    end

    chk("enough_deliveries", {31'd0, (deliveries >= 100)}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("rnd_perf", perf_fetch_cnt, perf_exp);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
